// File: rtl/vc_mem_arb3.sv
// vc_mem_arb3: three-port val/rdy arbiter onto one in-order memory port.
// Define VC_MEM_ARB3_FIXED_PRIO_EN for fixed priority 0 > 1 > 2.
module vc_mem_arb3 #(
  parameter int p_addr_sz   = 16,
  parameter int p_data_sz   = 32,
  parameter int p_tag_depth = 4,
  localparam int LEN_SZ  = $clog2(p_data_sz/8),
  localparam int REQ_SZ  = 1 + p_addr_sz + LEN_SZ + p_data_sz,
  localparam int RESP_SZ = 1 + LEN_SZ + p_data_sz
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memreq0_val,
  output logic               memreq0_rdy,
  input  logic [REQ_SZ-1:0]  memreq0_msg,
  input  logic               memreq1_val,
  output logic               memreq1_rdy,
  input  logic [REQ_SZ-1:0]  memreq1_msg,
  input  logic               memreq2_val,
  output logic               memreq2_rdy,
  input  logic [REQ_SZ-1:0]  memreq2_msg,
  output logic               memresp0_val,
  input  logic               memresp0_rdy,
  output logic [RESP_SZ-1:0] memresp0_msg,
  output logic               memresp1_val,
  input  logic               memresp1_rdy,
  output logic [RESP_SZ-1:0] memresp1_msg,
  output logic               memresp2_val,
  input  logic               memresp2_rdy,
  output logic [RESP_SZ-1:0] memresp2_msg,
  output logic               mem_memreq_val,
  input  logic               mem_memreq_rdy,
  output logic [REQ_SZ-1:0]  mem_memreq_msg,
  input  logic               mem_memresp_val,
  output logic               mem_memresp_rdy,
  input  logic [RESP_SZ-1:0] mem_memresp_msg
);

  localparam int PW = $clog2(p_tag_depth);

  logic [1:0]    r_tags [p_tag_depth];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic [2:0] w_val;
  logic [2:0] w_rsp_rdy;
  logic [1:0] w_gid;
  logic [1:0] w_head;
  logic       w_any;
  logic       w_full;
  logic       w_empty;
  logic       w_req_ok;
  logic       w_push;
  logic       w_pop;

  assign w_val     = {memreq2_val, memreq1_val, memreq0_val};
  assign w_rsp_rdy = {memresp2_rdy, memresp1_rdy, memresp0_rdy};
  assign w_any     = |w_val;
  assign w_full    = (r_count == (PW+1)'(p_tag_depth));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_tags[r_rptr];

`ifdef VC_MEM_ARB3_FIXED_PRIO_EN
  // Fixed priority: lowest-numbered valid port wins
  always_comb begin
    w_gid = 2'd2;
    if (w_val[0])      w_gid = 2'd0;
    else if (w_val[1]) w_gid = 2'd1;
  end
`else
  logic [1:0] r_prio;
  logic [1:0] w_p1;
  logic [1:0] w_p2;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_p1 = f_inc(r_prio);
  assign w_p2 = f_inc(w_p1);

  // Round-robin: scan from the port holding top priority
  always_comb begin
    w_gid = r_prio;
    if (w_val[r_prio])    w_gid = r_prio;
    else if (w_val[w_p1]) w_gid = w_p1;
    else if (w_val[w_p2]) w_gid = w_p2;
  end

  // Port after the last winner becomes top priority
  always_ff @(posedge clk) begin
    if (reset)       r_prio <= 2'd0;
    else if (w_push) r_prio <= f_inc(w_gid);
  end
`endif

  assign w_req_ok       = w_any & mem_memreq_rdy & ~w_full;
  assign mem_memreq_val = w_any & ~w_full;
  assign memreq0_rdy    = w_req_ok & (w_gid == 2'd0);
  assign memreq1_rdy    = w_req_ok & (w_gid == 2'd1);
  assign memreq2_rdy    = w_req_ok & (w_gid == 2'd2);

  // Forward the granted request message unchanged
  always_comb begin
    mem_memreq_msg = memreq0_msg;
    unique case (1'b1)
      (w_gid == 2'd1): mem_memreq_msg = memreq1_msg;
      (w_gid == 2'd2): mem_memreq_msg = memreq2_msg;
      default: ;
    endcase
  end

  assign w_push = mem_memreq_val & mem_memreq_rdy;
  assign w_pop  = mem_memresp_val & mem_memresp_rdy;

  // Responses go to the oldest outstanding requester
  assign mem_memresp_rdy = w_rsp_rdy[w_head] & ~w_empty;
  assign memresp0_val = mem_memresp_val & ~w_empty & (w_head == 2'd0);
  assign memresp1_val = mem_memresp_val & ~w_empty & (w_head == 2'd1);
  assign memresp2_val = mem_memresp_val & ~w_empty & (w_head == 2'd2);
  assign memresp0_msg = mem_memresp_msg;
  assign memresp1_msg = mem_memresp_msg;
  assign memresp2_msg = mem_memresp_msg;

  // Tag storage: record the winner of each memory request
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wptr] <= w_gid;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_mem_arb3.sv
// tb_vc_mem_arb3: directed vectors plus scoreboarded sequences.
// Define VC_MEM_ARB3_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_vc_mem_arb3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = $clog2(DW/8);
  localparam int REQ_SZ  = 1 + AW + LW + DW;
  localparam int RESP_SZ = 1 + LW + DW;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] rq_val, rq_rdy, rs_val, rs_rdy;
  logic [REQ_SZ-1:0]  rq_msg [3];
  logic [RESP_SZ-1:0] rs_msg [3];
  logic m_rq_val, m_rq_rdy, m_rs_val, m_rs_rdy;
  logic [REQ_SZ-1:0]  m_rq_msg;
  logic [RESP_SZ-1:0] m_rs_msg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]      mem [1024];
  logic [RESP_SZ-1:0] mq [$];
  int                 expq [$];
  int                 glog [$];
  int                 nfire [3];
  int                 rcnt [3];
  logic [RESP_SZ-1:0] rlast [3];
  bit model_on, mem_go, rand_rdy;

  typedef struct {
    logic [2:0] rv;
    logic       mrdy;
    logic       mrv;
    logic [2:0] srdy;
    logic [2:0] e_rqrdy;
    logic       e_mval;
    logic [2:0] e_srv;
    logic       e_msrdy;
  } vec_t;
  vec_t tv [14];

  always #5 clk = ~clk;

  vc_mem_arb3 #(.p_addr_sz(AW), .p_data_sz(DW), .p_tag_depth(4)) dut (
    .clk(clk), .reset(reset),
    .memreq0_val(rq_val[0]), .memreq0_rdy(rq_rdy[0]), .memreq0_msg(rq_msg[0]),
    .memreq1_val(rq_val[1]), .memreq1_rdy(rq_rdy[1]), .memreq1_msg(rq_msg[1]),
    .memreq2_val(rq_val[2]), .memreq2_rdy(rq_rdy[2]), .memreq2_msg(rq_msg[2]),
    .memresp0_val(rs_val[0]), .memresp0_rdy(rs_rdy[0]), .memresp0_msg(rs_msg[0]),
    .memresp1_val(rs_val[1]), .memresp1_rdy(rs_rdy[1]), .memresp1_msg(rs_msg[1]),
    .memresp2_val(rs_val[2]), .memresp2_rdy(rs_rdy[2]), .memresp2_msg(rs_msg[2]),
    .mem_memreq_val(m_rq_val), .mem_memreq_rdy(m_rq_rdy),
    .mem_memreq_msg(m_rq_msg),
    .mem_memresp_val(m_rs_val), .mem_memresp_rdy(m_rs_rdy),
    .mem_memresp_msg(m_rs_msg)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_model();
    m_rs_val = mem_go && (mq.size() > 0);
    m_rs_msg = (mq.size() > 0) ? mq[0] : '0;
  endtask

  // One clock: sample handshakes before the edge, update model after it
  task automatic tick();
    logic [REQ_SZ-1:0] q;
    logic [AW-1:0] a;
    @(negedge clk);
    if (reset) begin
      mq.delete();
      expq.delete();
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (rq_val[n] && rq_rdy[n]) begin
          glog.push_back(n);
          expq.push_back(n);
          nfire[n]++;
        end
        if (rs_val[n] && rs_rdy[n]) begin
          rcnt[n]++;
          rlast[n] = rs_msg[n];
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_unexpected: port %0d got a response, none owed", n);
          end else
            chk("resp_port", n, expq.pop_front());
        end
      end
      if (model_on) begin
        if (m_rs_val && m_rs_rdy) void'(mq.pop_front());
        if (m_rq_val && m_rq_rdy) begin
          q = m_rq_msg;
          a = q[LW+DW +: AW];
          if (q[REQ_SZ-1]) begin
            mem[a[9:0]] = q[DW-1:0];
            mq.push_back({1'b1, LW'(0), DW'(0)});
          end else
            mq.push_back({1'b0, LW'(0), mem[a[9:0]]});
        end
      end
    end
    @(posedge clk);
    #1;
    if (model_on) drive_model();
    if (rand_rdy) rs_rdy = 3'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq_val = '0;
    tick();
    tick();
    reset = 1'b0;
    glog.delete();
    nfire = '{0, 0, 0};
    rcnt  = '{0, 0, 0};
  endtask

  task automatic drain();
    rq_val = '0;
    mem_go = 1'b1;
    drive_model();
    for (int c = 0; c < 60 && expq.size() > 0; c++) tick();
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic issue(input int n, input logic [REQ_SZ-1:0] m);
    bit done;
    done = 1'b0;
    rq_msg[n] = m;
    rq_val[n] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      done = rq_rdy[n];
      tick();
    end
    rq_val[n] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: port %0d got 0 grants, want 1", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rq_val = '0;
    rs_rdy = '0;
    m_rq_rdy = 1'b0;
    m_rs_val = 1'b0;
    m_rs_msg = '0;
    model_on = 1'b0;
    mem_go = 1'b0;
    rand_rdy = 1'b0;
    for (int n = 0; n < 3; n++) rq_msg[n] = '0;
    nfire = '{0, 0, 0};
    rcnt  = '{0, 0, 0};
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rqrdy", rq_rdy, 3'b000);
    chk("rst_mval", m_rq_val, 1'b0);
    chk("rst_srv", rs_val, 3'b000);
    chk("rst_msrdy", m_rs_rdy, 1'b0);

    m_rs_val = 1'b1;
    rs_rdy = 3'b111;
    #1;
    chk("empty_msrdy", m_rs_rdy, 1'b0);
    chk("empty_srv", rs_val, 3'b000);
    m_rs_val = 1'b0;
    tick();

`ifndef VC_MEM_ARB3_FIXED_PRIO_EN
    tv[0]  = '{3'b111, 1, 1, 3'b111, 3'b001, 1, 3'b000, 0};
    tv[1]  = '{3'b101, 1, 0, 3'b111, 3'b100, 1, 3'b000, 1};
    tv[2]  = '{3'b011, 0, 1, 3'b000, 3'b000, 1, 3'b001, 0};
    tv[3]  = '{3'b010, 1, 1, 3'b001, 3'b010, 1, 3'b001, 1};
    tv[4]  = '{3'b000, 1, 1, 3'b011, 3'b000, 0, 3'b100, 0};
    tv[5]  = '{3'b111, 1, 1, 3'b100, 3'b100, 1, 3'b100, 1};
    tv[6]  = '{3'b110, 1, 0, 3'b111, 3'b010, 1, 3'b000, 1};
    tv[7]  = '{3'b011, 1, 1, 3'b010, 3'b001, 1, 3'b010, 1};
    tv[8]  = '{3'b000, 0, 1, 3'b111, 3'b000, 0, 3'b100, 1};
    tv[9]  = '{3'b000, 0, 1, 3'b111, 3'b000, 0, 3'b010, 1};
    tv[10] = '{3'b000, 0, 1, 3'b111, 3'b000, 0, 3'b001, 1};
    tv[11] = '{3'b000, 0, 1, 3'b111, 3'b000, 0, 3'b000, 0};
    tv[12] = '{3'b111, 1, 0, 3'b000, 3'b010, 1, 3'b000, 0};
    tv[13] = '{3'b000, 1, 1, 3'b111, 3'b000, 0, 3'b010, 1};
    for (int i = 0; i < 14; i++) begin
      rq_val = tv[i].rv;
      m_rq_rdy = tv[i].mrdy;
      m_rs_val = tv[i].mrv;
      rs_rdy = tv[i].srdy;
      #1;
      chk($sformatf("v%0d_rqrdy", i), rq_rdy, tv[i].e_rqrdy);
      chk($sformatf("v%0d_mval", i), m_rq_val, tv[i].e_mval);
      chk($sformatf("v%0d_srv", i), rs_val, tv[i].e_srv);
      chk($sformatf("v%0d_msrdy", i), m_rs_rdy, tv[i].e_msrdy);
      tick();
    end
    rq_val = '0;
    m_rs_val = 1'b0;

    do_reset();
    model_on = 1'b1;
    mem_go = 1'b1;
    m_rq_rdy = 1'b1;
    rs_rdy = 3'b111;
    drive_model();
    for (int n = 0; n < 3; n++)
      rq_msg[n] = {1'b1, AW'(16'h0100 + n*4), LW'(0), DW'(32'h1000 + n)};
    rq_val = 3'b111;
    for (int c = 0; c < 6; c++) tick();
    rq_val = '0;
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_gnt%0d", k), (glog.size() > k) ? glog[k] : 9, k % 3);
    drain();
    for (int n = 0; n < 3; n++)
      chk($sformatf("rr_resp_cnt%0d", n), rcnt[n], 2);
`else
    do_reset();
    model_on = 1'b1;
    mem_go = 1'b1;
    m_rq_rdy = 1'b1;
    rs_rdy = 3'b111;
    drive_model();
    rq_msg[0] = {1'b1, AW'(16'h0200), LW'(0), DW'(32'h0a0a0a0a)};
    rq_msg[1] = {1'b1, AW'(16'h0204), LW'(0), DW'(32'h0b0b0b0b)};
    rq_val = 3'b011;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("fx_rdy1_%0d", c), rq_rdy[1], 1'b0);
      chk($sformatf("fx_rdy0_%0d", c), rq_rdy[0], 1'b1);
      tick();
    end
    drain();
    chk("fx_p1_fires", nfire[1], 0);
`endif

    do_reset();
    model_on = 1'b1;
    mem_go = 1'b0;
    m_rq_rdy = 1'b1;
    rs_rdy = 3'b111;
    drive_model();
    rq_msg[0] = {1'b0, AW'(16'h0010), LW'(0), DW'(0)};
    rq_val = 3'b001;
    for (int c = 0; c < 8; c++) tick();
    #1;
    chk("full_fires", nfire[0], 4);
    chk("full_rdy0", rq_rdy[0], 1'b0);
    mem_go = 1'b1;
    drive_model();
    #1;
    chk("full_pop_rdy0", rq_rdy[0], 1'b0);
    chk("full_msrdy", m_rs_rdy, 1'b1);
    tick();
    mem_go = 1'b0;
    drive_model();
    #1;
    chk("after_pop_rdy0", rq_rdy[0], 1'b1);
    tick();
    #1;
    chk("refill_rdy0", rq_rdy[0], 1'b0);
    tick();
    tick();
    chk("refill_fires", nfire[0], 5);
    drain();

    do_reset();
    model_on = 1'b1;
    mem_go = 1'b1;
    m_rq_rdy = 1'b1;
    rand_rdy = 1'b1;
    drive_model();
    issue(2, {1'b1, AW'(16'h03e8), LW'(0), DW'(32'hdeadbeef)});
    issue(2, {1'b0, AW'(16'h03e8), LW'(0), DW'(0)});
    for (int c = 0; c < 200 && rcnt[2] < 2; c++) tick();
    chk("p2_resp_cnt", rcnt[2], 2);
    chk("p2_rd_data", rlast[2][DW-1:0], 32'hdeadbeef);
    chk("p2_rd_type", rlast[2][RESP_SZ-1], 1'b0);
    chk("p0_resp_cnt", rcnt[0], 0);
    chk("p1_resp_cnt", rcnt[1], 0);
    rand_rdy = 1'b0;
    rs_rdy = 3'b111;

`ifndef VC_MEM_ARB3_FIXED_PRIO_EN
    do_reset();
    model_on = 1'b1;
    mem_go = 1'b0;
    m_rq_rdy = 1'b1;
    drive_model();
    rq_val = 3'b111;
    tick();
    tick();
    rq_val = 3'b010;
    tick();
    rq_val = 3'b111;
    #1;
    chk("pre_rst_gnt", rq_rdy, 3'b100);
    rq_val = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_on = 1'b0;
    m_rs_val = 1'b1;
    rs_rdy = 3'b111;
    #1;
    chk("midrst_msrdy", m_rs_rdy, 1'b0);
    chk("midrst_srv", rs_val, 3'b000);
    m_rs_val = 1'b0;
    rq_val = 3'b111;
    #1;
    chk("midrst_gnt0", rq_rdy, 3'b001);
    tick();
    #1;
    chk("midrst_gnt1", rq_rdy, 3'b010);
    rq_val = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
